periph_bus: RTL and testbench

- Memory-mapped peripheral block in the single-cycle MIPS CPU, directly downstream of the ALU.
- It decodes the load/store address (the ALU result) and services reads and writes on the peripheral region.
- It holds a 32-bit reload timer with interrupt, LED/seven-segment output registers, a switch input, and a byte UART TX/RX holding interface with valid/ready handshakes.
- irqout feeds the CPU interrupt logic; rdata is muxed with data-memory read data by the writeback path.

---
 rtl/periph_bus.sv | 103 ++++++++++
 tb/tb_periph_bus.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// periph_bus: memory-mapped timer, LED/seven-segment, switch and UART holding registers
module periph_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter logic [31:0] TH_RST    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic        irqout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d, txd_q, txd_d, rxd_q, rxd_d;
    logic [11:0] digi_q, digi_d;
    logic        tx_valid_q, tx_valid_d, rx_full_q, rx_full_d, ovr_q, ovr_d;
    logic [29:0] wofs;
    logic        in_map, wrap, rd_rxd, tx_load;
    logic        unused_bits;

    assign unused_bits = ^addr[1:0];
    assign wofs    = addr[31:2] - BASE_ADDR[31:2];
    assign in_map  = wofs < 30'd9;
    assign rd_rxd  = rd && in_map && wofs[3:0] == 4'd7;
    assign wrap    = tcon_q[0] && tl_q == 32'hFFFFFFFF;
    assign tx_load = wr && in_map && wofs[3:0] == 4'd6 && !tx_valid_q;

    always_comb begin
        th_d       = (wr && in_map && wofs[3:0] == 4'd0) ? wdata : th_q;
        tl_d       = (wr && in_map && wofs[3:0] == 4'd1) ? wdata :
                     wrap ? th_q : tcon_q[0] ? tl_q + 32'd1 : tl_q;
        tcon_d     = (wr && in_map && wofs[3:0] == 4'd2) ? wdata[2:0] :
                     {tcon_q[2] | (wrap & tcon_q[1]), tcon_q[1:0]};
        led_d      = (wr && in_map && wofs[3:0] == 4'd3) ? wdata[7:0] : led_q;
        digi_d     = (wr && in_map && wofs[3:0] == 4'd5) ? wdata[11:0] : digi_q;
        txd_d      = tx_load ? wdata[7:0] : txd_q;
        tx_valid_d = tx_load ? 1'b1 : (tx_valid_q && tx_ready) ? 1'b0 : tx_valid_q;
        rxd_d      = rx_valid ? rx_data : rxd_q;
        rx_full_d  = rx_valid ? 1'b1 : rd_rxd ? 1'b0 : rx_full_q;
        ovr_d      = ovr_q | (rx_valid & rx_full_q & ~rd_rxd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q       <= TH_RST;
            tl_q       <= TH_RST;
            tcon_q     <= '0;
            led_q      <= '0;
            digi_q     <= '0;
            txd_q      <= '0;
            tx_valid_q <= 1'b0;
            rxd_q      <= '0;
            rx_full_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            tcon_q     <= tcon_d;
            led_q      <= led_d;
            digi_q     <= digi_d;
            txd_q      <= txd_d;
            tx_valid_q <= tx_valid_d;
            rxd_q      <= rxd_d;
            rx_full_q  <= rx_full_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && in_map) begin
            case (wofs[3:0])
                4'd0:    rdata = th_q;
                4'd1:    rdata = tl_q;
                4'd2:    rdata = {29'b0, tcon_q};
                4'd3:    rdata = {24'b0, led_q};
                4'd4:    rdata = {24'b0, switch};
                4'd5:    rdata = {20'b0, digi_q};
                4'd6:    rdata = {24'b0, txd_q};
                4'd7:    rdata = {24'b0, rxd_q};
                4'd8:    rdata = {27'b0, ovr_q, rx_full_q, tx_valid_q, 2'b00};
                default: rdata = '0;
            endcase
        end
    end

    assign led      = led_q;
    assign digi     = digi_q;
    assign irqout   = tcon_q[2];
    assign tx_data  = txd_q;
    assign tx_valid = tx_valid_q;
endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: directed checks of the timer, UART holding registers and address decode
module tb_periph_bus;
    localparam logic [31:0] B = 32'h40000000;
    logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
    logic        tx_ready = 1'b0, rx_valid = 1'b0, irqout, tx_valid;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [7:0]  led, switch = '0, tx_data, rx_data = '0;
    logic [11:0] digi;
    int          n_run = 0, n_fail = 0;

    periph_bus dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [31:0] off, input logic [31:0] d);
        addr = B + off;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        addr = B + off;
        rd = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b1;
        tick();
        chk("rst_led", {24'b0, led}, 32'h0);
        chk("rst_digi", {20'b0, digi}, 32'h0);
        chk("rst_irq", {31'b0, irqout}, 32'h0);
        chk("rst_txv", {31'b0, tx_valid}, 32'h0);
        rd_chk("rst_tl", 32'h04, 32'h0);
        rd_chk("rst_ucon", 32'h20, 32'h0);

        wr_w(32'h04, 32'h5);
        wr_w(32'h18, 32'h33);
        wr_w(32'h08, 32'h1);
        rd_chk("pre_rst_tl", 32'h04, 32'h5);
        chk("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
        reset = 1'b0;
        #1;
        chk("async_txv", {31'b0, tx_valid}, 32'h0);
        chk("async_irq", {31'b0, irqout}, 32'h0);
        rd_chk("async_tl", 32'h04, 32'h0);
        reset = 1'b1;
        tick();

        wr_w(32'h00, 32'hFFFFFFFC);
        wr_w(32'h04, 32'hFFFFFFFE);
        wr_w(32'h08, 32'h3);
        rd_chk("tl_start", 32'h04, 32'hFFFFFFFE);
        tick();
        rd_chk("tl_ff", 32'h04, 32'hFFFFFFFF);
        chk("irq_pre", {31'b0, irqout}, 32'h0);
        tick();
        rd_chk("tl_reload", 32'h04, 32'hFFFFFFFC);
        chk("irq_set", {31'b0, irqout}, 32'h1);
        wr_w(32'h08, 32'h1);
        chk("irq_clr", {31'b0, irqout}, 32'h0);
        rd_chk("tl_cont", 32'h04, 32'hFFFFFFFD);
        tick();
        rd_chk("tl_cont2", 32'h04, 32'hFFFFFFFE);

        wr_w(32'h08, 32'h3);
        rd_chk("coll_pre", 32'h04, 32'hFFFFFFFF);
        wr_w(32'h04, 32'h10);
        rd_chk("coll_tl", 32'h04, 32'h10);
        chk("coll_irq", {31'b0, irqout}, 32'h1);
        wr_w(32'h08, 32'h0);
        rd_chk("tcon_off", 32'h08, 32'h0);

        wr_w(32'h18, 32'h41);
        chk("tx_valid", {31'b0, tx_valid}, 32'h1);
        chk("tx_data", {24'b0, tx_data}, 32'h41);
        rd_chk("ucon_busy", 32'h20, 32'h4);
        wr_w(32'h18, 32'h42);
        chk("tx_drop", {24'b0, tx_data}, 32'h41);
        rd_chk("txd_read", 32'h18, 32'h41);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("tx_done", {31'b0, tx_valid}, 32'h0);
        rd_chk("ucon_idle", 32'h20, 32'h0);
        wr_w(32'h18, 32'h50);
        tx_ready = 1'b1;
        wr_w(32'h18, 32'h51);
        tx_ready = 1'b0;
        chk("tx_hs_wr_v", {31'b0, tx_valid}, 32'h0);
        chk("tx_hs_wr_d", {24'b0, tx_data}, 32'h50);

        rx_valid = 1'b1;
        rx_data = 8'h55;
        tick();
        rx_data = 8'h66;
        tick();
        rx_valid = 1'b0;
        rd_chk("rxd_66", 32'h1C, 32'h66);
        rd_chk("ucon_ovr", 32'h20, 32'h18);
        addr = B + 32'h1C;
        rd = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h77;
        #1;
        chk("rx_simul_old", rdata, 32'h66);
        tick();
        rd = 1'b0;
        rx_valid = 1'b0;
        rd_chk("rxd_77", 32'h1C, 32'h77);
        rd_chk("ucon_full", 32'h20, 32'h18);
        addr = B + 32'h1C;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        rd_chk("ucon_drain", 32'h20, 32'h10);

        switch = 8'hA5;
        rd_chk("sw_10", 32'h10, 32'hA5);
        rd_chk("sw_13", 32'h13, 32'hA5);
        rd_chk("unmapped", 32'h24, 32'h0);
        addr = B + 32'h10;
        #1;
        chk("no_rd", rdata, 32'h0);
        wr_w(32'h0C, 32'h1FF);
        chk("led_ff", {24'b0, led}, 32'hFF);
        wr_w(32'h14, 32'hFFFF);
        chk("digi_fff", {20'b0, digi}, 32'hFFF);
        addr = B + 32'h0C;
        wdata = 32'h12;
        rd = 1'b1;
        wr = 1'b1;
        #1;
        chk("rdwr_old", rdata, 32'hFF);
        tick();
        rd = 1'b0;
        wr = 1'b0;
        chk("rdwr_new", {24'b0, led}, 32'h12);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
